// File: rtl/sh4_fpwb_arb.sv
// FP register-file write-back arbiter: round-robin over NREQ requesters into two
// 32-bit write slots per cycle, with registered register-file write ports.
module sh4_fpwb_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_pair,
  input  logic [4*NREQ-1:0]    req_dst,
  input  logic [NREQ-1:0]      req_bank,
  input  logic [64*NREQ-1:0]   req_data,
  output logic                 rf_wen0,
  output logic                 rf_wen1,
  output logic [3:0]           rf_wdst0,
  output logic [3:0]           rf_wdst1,
  output logic                 rf_wbank0,
  output logic                 rf_wbank1,
  output logic [31:0]          rf_wdata0,
  output logic [31:0]          rf_wdata1
);

  localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]  rr, rr_next;
  logic [NREQ-1:0] grant;
  logic            s0_use, s1_use, first_found;
  logic [4:0]      s0_key, s1_key, key;
  logic [31:0]     s0_data, s1_data;
  logic [RRW-1:0]  idx;
  int unsigned     pos;

  logic [3:0]  dst_a  [NREQ];
  logic [63:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign dst_a[g]  = req_dst[g*4 +: 4];
    assign data_a[g] = req_data[g*64 +: 64];
  end

  // Slots fill lowest-first, so slot0 free implies nothing granted yet this cycle;
  // only a single landing in slot1 needs a destination-conflict check.
  always_comb begin
    grant       = '0;
    s0_use      = 1'b0;
    s1_use      = 1'b0;
    s0_key      = '0;
    s1_key      = '0;
    s0_data     = '0;
    s1_data     = '0;
    rr_next     = rr;
    first_found = 1'b0;
    pos         = 0;
    idx         = '0;
    key         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = k + 32'(rr);
      if (pos >= NREQ) pos = pos - NREQ;
      idx = RRW'(pos);
      key = {req_bank[idx], dst_a[idx]};
      if (req_valid[idx] && !stall && !rst) begin
        if (req_pair[idx]) begin
          if (!s0_use) begin
            grant[idx] = 1'b1;
            s0_use     = 1'b1;
            s1_use     = 1'b1;
            s0_key     = {req_bank[idx], dst_a[idx][3:1], 1'b0};
            s1_key     = {req_bank[idx], dst_a[idx][3:1], 1'b1};
            s0_data    = data_a[idx][63:32];
            s1_data    = data_a[idx][31:0];
          end
        end else if (!s0_use) begin
          grant[idx] = 1'b1;
          s0_use     = 1'b1;
          s0_key     = key;
          s0_data    = data_a[idx][31:0];
        end else if (!s1_use && (key != s0_key)) begin
          grant[idx] = 1'b1;
          s1_use     = 1'b1;
          s1_key     = key;
          s1_data    = data_a[idx][31:0];
        end
        if (grant[idx] && !first_found) begin
          first_found = 1'b1;
          rr_next     = (idx == RRW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr        <= '0;
      rf_wen0   <= 1'b0;
      rf_wen1   <= 1'b0;
      rf_wdst0  <= '0;
      rf_wdst1  <= '0;
      rf_wbank0 <= 1'b0;
      rf_wbank1 <= 1'b0;
      rf_wdata0 <= '0;
      rf_wdata1 <= '0;
    end else begin
      rr      <= rr_next;
      rf_wen0 <= s0_use;
      rf_wen1 <= s1_use;
      if (s0_use) begin
        {rf_wbank0, rf_wdst0} <= s0_key;
        rf_wdata0             <= s0_data;
      end
      if (s1_use) begin
        {rf_wbank1, rf_wdst1} <= s1_key;
        rf_wdata1             <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_sh4_fpwb_arb.sv
// Bench for sh4_fpwb_arb: directed scenarios plus randomized traffic, all checked
// against a queue-based slot/destination model of the arbitration rules.
module tb_sh4_fpwb_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic [2:0]   req_valid, req_ready, req_pair, req_bank;
  logic [11:0]  req_dst;
  logic [191:0] req_data;
  logic         rf_wen0, rf_wen1, rf_wbank0, rf_wbank1;
  logic [3:0]   rf_wdst0, rf_wdst1;
  logic [31:0]  rf_wdata0, rf_wdata1;

  sh4_fpwb_arb #(.NREQ(3)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_pair(req_pair),
    .req_dst(req_dst), .req_bank(req_bank), .req_data(req_data),
    .rf_wen0(rf_wen0), .rf_wen1(rf_wen1),
    .rf_wdst0(rf_wdst0), .rf_wdst1(rf_wdst1),
    .rf_wbank0(rf_wbank0), .rf_wbank1(rf_wbank1),
    .rf_wdata0(rf_wdata0), .rf_wdata1(rf_wdata1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Pending request per requester (held until granted)
  logic [2:0]  pv = '0, pp = '0, pb = '0;
  logic [3:0]  pd   [3];
  logic [63:0] pdat [3];

  // Reference model state
  int          mrr = 0;
  logic        e_wen0, e_wen1;
  logic [4:0]  e_key0, e_key1;
  logic [31:0] e_dat0, e_dat1;
  logic [2:0]  m_rdy, seen_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    req_valid = pv;
    req_pair  = pp;
    req_bank  = pb;
    for (int i = 0; i < 3; i++) begin
      req_dst[i*4 +: 4]    = pd[i];
      req_data[i*64 +: 64] = pdat[i];
    end
  endtask

  task automatic set_req(input int i, input logic pair, input logic bank,
                         input logic [3:0] dst, input logic [63:0] data);
    pv[i] = 1'b1; pp[i] = pair; pb[i] = bank; pd[i] = dst; pdat[i] = data;
  endtask

  task automatic new_rand(input int i);
    pv[i]   = ($urandom % 4) != 0;
    pp[i]   = ($urandom % 4) == 0;
    pb[i]   = 1'($urandom % 2);
    pd[i]   = 4'($urandom_range(0, 7));
    pdat[i] = {$urandom, $urandom};
  endtask

  // One handshake cycle: check ready, predict, clock, check registered writes.
  task automatic step();
    logic [4:0]  keys[$];
    logic [31:0] dats[$];
    logic [4:0]  ka, kb;
    int          i, first, need;
    logic        hit;
    drive();
    #1;
    m_rdy = '0;
    first = -1;
    if (!stall) begin
      for (int k = 0; k < 3; k++) begin
        i = (mrr + k) % 3;
        if (!pv[i]) continue;
        if (pp[i]) begin
          ka = {pb[i], pd[i][3:1], 1'b0};
          kb = {pb[i], pd[i][3:1], 1'b1};
          need = 2;
        end else begin
          ka = {pb[i], pd[i]};
          kb = ka;
          need = 1;
        end
        if (keys.size() + need > 2) continue;
        hit = 1'b0;
        foreach (keys[j]) if (keys[j] == ka || keys[j] == kb) hit = 1'b1;
        if (hit) continue;
        if (pp[i]) begin
          keys.push_back(ka); dats.push_back(pdat[i][63:32]);
          keys.push_back(kb); dats.push_back(pdat[i][31:0]);
        end else begin
          keys.push_back(ka); dats.push_back(pdat[i][31:0]);
        end
        m_rdy[i] = 1'b1;
        if (first < 0) first = i;
      end
    end
    seen_rdy = req_ready;
    check("ready", 64'(req_ready), 64'(m_rdy));
    if (first >= 0) mrr = (first + 1) % 3;
    e_wen0 = keys.size() >= 1;
    e_wen1 = keys.size() >= 2;
    if (e_wen0) begin e_key0 = keys[0]; e_dat0 = dats[0]; end
    if (e_wen1) begin e_key1 = keys[1]; e_dat1 = dats[1]; end
    @(posedge clk);
    #1;
    check("wen",   64'({rf_wen0, rf_wen1}), 64'({e_wen0, e_wen1}));
    check("key0",  64'({rf_wbank0, rf_wdst0}), 64'(e_key0));
    check("data0", 64'(rf_wdata0), 64'(e_dat0));
    check("key1",  64'({rf_wbank1, rf_wdst1}), 64'(e_key1));
    check("data1", 64'(rf_wdata1), 64'(e_dat1));
    if (rf_wen0 && rf_wen1)
      check("dual_dst", 64'({rf_wbank0, rf_wdst0} == {rf_wbank1, rf_wdst1}), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_wen",   64'({rf_wen0, rf_wen1}), 64'(0));
    check("rst_regs",  64'({rf_wbank0, rf_wdst0, rf_wbank1, rf_wdst1}), 64'(0));
    check("rst_data",  {rf_wdata0, rf_wdata1}, 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mrr = 0;
    e_wen0 = 1'b0; e_wen1 = 1'b0;
    e_key0 = '0; e_key1 = '0; e_dat0 = '0; e_dat1 = '0;
  endtask

  task automatic three_singles();
    set_req(0, 1'b0, 1'b0, 4'd1, 64'h0000_0000_A000_0001);
    set_req(1, 1'b0, 1'b0, 4'd2, 64'h0000_0000_A000_0002);
    set_req(2, 1'b0, 1'b1, 4'd3, 64'h0000_0000_A000_0003);
  endtask

  int last[3];

  initial begin
    for (int i = 0; i < 3; i++) begin pd[i] = '0; pdat[i] = '0; end
    drive();
    #2;
    do_reset();

    // Two singles, distinct destinations
    set_req(0, 1'b0, 1'b0, 4'd3, 64'h0000_0000_1111_1111);
    set_req(1, 1'b0, 1'b1, 4'd4, 64'h0000_0000_2222_2222);
    step();
    check("d1_slot0", {27'd0, rf_wen0, rf_wbank0, rf_wdst0, rf_wdata0}, {27'd0, 1'b1, 1'b0, 4'd3, 32'h1111_1111});
    check("d1_slot1", {27'd0, rf_wen1, rf_wbank1, rf_wdst1, rf_wdata1}, {27'd0, 1'b1, 1'b1, 4'd4, 32'h2222_2222});
    three_singles();
    step();
    check("d1_rr1", 64'(seen_rdy), 64'(3'b110));

    // Pair skipped for lack of slots, granted next cycle
    pv = '0;
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'd2, 64'h0000_0000_0000_0C02);
    set_req(1, 1'b1, 1'b0, 4'd5, 64'hAAAA_AAAA_BBBB_BBBB);
    set_req(2, 1'b0, 1'b0, 4'd9, 64'h0000_0000_0000_0C09);
    step();
    check("d2_first", 64'(seen_rdy), 64'(3'b101));
    pv = 3'b010;
    step();
    check("d2_pair0", {rf_wdst0, rf_wdata0}, {28'd0, 4'd4, 32'hAAAA_AAAA});
    check("d2_pair1", {rf_wdst1, rf_wdata1}, {28'd0, 4'd5, 32'hBBBB_BBBB});

    // Same-destination conflict
    pv = '0;
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'd7, 64'h0000_0000_7000_0000);
    set_req(1, 1'b0, 1'b0, 4'd7, 64'h0000_0000_7000_0001);
    step();
    pv[0] = 1'b0;
    step();

    // Stall holds off all grants and leaves the pointer alone
    pv = '0;
    do_reset();
    three_singles();
    step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    step();
    check("stall_resume", 64'(seen_rdy), 64'(3'b110));

    // Fairness: singles, then with a pair in the mix
    for (int pass = 0; pass < 2; pass++) begin
      pv = '0;
      do_reset();
      three_singles();
      if (pass == 1) set_req(1, 1'b1, 1'b1, 4'd6, 64'hCAFE_0001_CAFE_0002);
      for (int i = 0; i < 3; i++) last[i] = -1;
      for (int c = 0; c < 6; c++) begin
        step();
        for (int i = 0; i < 3; i++) begin
          if (seen_rdy[i]) last[i] = c;
          check("starve", 64'((c - last[i]) <= ((pass == 1 && i == 1) ? 2 : 1)), 64'(1));
        end
      end
    end

    // Reset in the cycle after a grant
    pv = '0;
    do_reset();
    three_singles();
    step();
    do_reset();
    step();
    check("rst_rr0", 64'(seen_rdy), 64'(3'b011));

    // Randomized traffic
    pv = '0;
    do_reset();
    for (int i = 0; i < 3; i++) new_rand(i);
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom % 8) == 0;
      step();
      for (int i = 0; i < 3; i++) begin
        if (pv[i] && m_rdy[i]) new_rand(i);
        else if (!pv[i] && ($urandom % 2) == 0) new_rand(i);
      end
      if (c == 200) do_reset();
    end
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
